// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position and jump/gravity controller; all motion commits on the vblank tick.
// Optional feature: define SPRITE_WRAP_EN for horizontal wrap-around instead of edge clamping.
module sprite_motion_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPRITE_W = 100,
  parameter int GROUND_Y = 280,
  parameter int START_X  = 270,
  parameter int STEP_X   = 4,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [9:0]         i_x,
  input  logic [9:0]         i_y,
  input  logic               i_btn_left,
  input  logic               i_btn_right,
  input  logic               i_btn_jump,
  output logic signed [10:0] o_sprite_x,
  output logic signed [10:0] o_sprite_y,
  output logic               o_frame_tick,
  output logic               o_airborne,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {GROUNDED = 2'd0, RISE = 2'd1, FALL = 2'd2, LAND = 2'd3} state_t;

  localparam logic signed [10:0] L_XMAX   = 11'(SCREEN_W - SPRITE_W);
  localparam logic signed [10:0] L_SCRW   = 11'(SCREEN_W);
  localparam logic signed [10:0] L_GROUND = 11'(GROUND_Y);
  localparam logic signed [10:0] L_STARTX = 11'(START_X);
  localparam logic signed [10:0] L_STEP   = 11'(STEP_X);
  localparam logic signed [7:0]  L_V0     = 8'(JUMP_V0);
  localparam logic signed [7:0]  L_GRAV   = 8'(GRAVITY);
  localparam logic signed [7:0]  L_MAXF   = 8'(MAX_FALL);
  localparam logic [9:0]         L_VBL    = 10'(SCREEN_H);

  state_t             r_state, w_state_nxt;
  logic signed [10:0] r_sx, r_sy, w_sx_nxt, w_sy_nxt, w_dx, w_nx, w_ny;
  logic signed [7:0]  r_vy, w_vy_nxt, w_vy_inc;
  logic [2:0]         r_sync1, r_sync2;  // {jump, right, left}
  logic [9:0]         r_y_prev;
  logic               r_tick;
  logic               w_unused;

  assign w_unused = ^i_x;

  // y_prev resets to the vblank line so a beam already parked there cannot fire a tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_y_prev <= L_VBL;
      r_tick   <= 1'b0;
    end else begin
      r_sync1  <= {i_btn_jump, i_btn_right, i_btn_left};
      r_sync2  <= r_sync1;
      r_y_prev <= i_y;
      r_tick   <= (i_y == L_VBL) && (r_y_prev != L_VBL);
    end
  end

  always_comb begin
    w_dx = '0;
    if (r_sync2[1] && !r_sync2[0])      w_dx = L_STEP;
    else if (r_sync2[0] && !r_sync2[1]) w_dx = -L_STEP;
    w_nx     = r_sx + w_dx;
    w_sx_nxt = w_nx;
`ifdef SPRITE_WRAP_EN
    if (w_nx > L_SCRW - 11'sd1) w_sx_nxt = w_nx - L_SCRW;
    else if (w_nx < 11'sd0)     w_sx_nxt = w_nx + L_SCRW;
`else
    if (w_nx > L_XMAX)      w_sx_nxt = L_XMAX;
    else if (w_nx < 11'sd0) w_sx_nxt = 11'sd0;
`endif
  end

  assign w_ny     = r_sy + $signed({{3{r_vy[7]}}, r_vy});
  assign w_vy_inc = r_vy + L_GRAV;

  always_comb begin
    w_state_nxt = r_state;
    w_sy_nxt    = r_sy;
    w_vy_nxt    = r_vy;
    case (r_state)
      GROUNDED: if (r_sync2[2]) begin
        w_vy_nxt    = -L_V0;
        w_state_nxt = RISE;
      end
      RISE: begin
        if (w_ny < 11'sd0) begin
          w_sy_nxt    = 11'sd0;
          w_vy_nxt    = 8'sd0;
          w_state_nxt = FALL;
        end else begin
          w_sy_nxt = w_ny;
          w_vy_nxt = w_vy_inc;
          if (w_vy_inc >= 8'sd0) w_state_nxt = FALL;
        end
      end
      FALL: begin
        if (w_ny >= L_GROUND) begin
          w_sy_nxt    = L_GROUND;
          w_vy_nxt    = 8'sd0;
          w_state_nxt = LAND;
        end else begin
          w_sy_nxt = w_ny;
          w_vy_nxt = (w_vy_inc > L_MAXF) ? L_MAXF : w_vy_inc;
        end
      end
      default: begin
        w_vy_nxt    = 8'sd0;
        w_state_nxt = GROUNDED;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     r_state <= GROUNDED;
    else if (r_tick) r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sx <= L_STARTX;
      r_sy <= L_GROUND;
      r_vy <= 8'sd0;
    end else if (r_tick) begin
      r_sx <= w_sx_nxt;
      r_sy <= w_sy_nxt;
      r_vy <= w_vy_nxt;
    end
  end

  always_comb begin
    o_airborne = (r_state == RISE) || (r_state == FALL);
    o_state    = r_state;
  end

  assign o_sprite_x   = r_sx;
  assign o_sprite_y   = r_sy;
  assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: frames push expected positions, a monitor checks after each tick.
module tb_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] bx, by;
  logic bl, br, bj;
  logic signed [10:0] sx, sy;
  logic tick, air;
  logic [1:0] st;

  sprite_motion_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_x(bx), .i_y(by),
    .i_btn_left(bl), .i_btn_right(br), .i_btn_jump(bj),
    .o_sprite_x(sx), .o_sprite_y(sy), .o_frame_tick(tick),
    .o_airborne(air), .o_state(st)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int st;} exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0, tick_cnt = 0, frames = 0, xm = 270;
  int rise_y[12] = '{268, 257, 247, 238, 230, 223, 217, 212, 208, 205, 203, 202};
  int fall_y[13] = '{202, 203, 205, 208, 212, 217, 223, 230, 238, 247, 257, 268, 280};

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int step_x(input int x0, input bit l, input bit r);
    int n;
    n = x0;
    if (r && !l) n = n + 4;
    else if (l && !r) n = n - 4;
`ifdef SPRITE_WRAP_EN
    if (n > 639) n = n - 640;
    else if (n < 0) n = n + 640;
`else
    if (n > 540) n = 540;
    else if (n < 0) n = 0;
`endif
    return n;
  endfunction

  task automatic line(input int v, input int n);
    by = 10'(v);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input bit l, input bit r, input bit j, input int ey, input int est);
    exp_t e;
    xm = step_x(xm, l, r);
    e.x = xm; e.y = ey; e.st = est;
    q.push_back(e);
    bl = l; br = r; bj = j;
    line(470, 4);
    line(480, 3);
    line(481, 3);
    frames++;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  // Monitor: tick marks the commit cycle; new outputs are checked one cycle later.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (tick === 1'b1) begin
      tick_cnt++;
      @(negedge clk);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_tick: tick with no frame pending at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("sprite_x", $signed(sx), e.x);
        chk("sprite_y", $signed(sy), e.y);
        chk("state", int'(st), e.st);
        chk("airborne", int'(air), (e.st == 1 || e.st == 2) ? 1 : 0);
        chk("tick_one_cycle", int'(tick), 0);
      end
    end
  end

  initial begin
    rst = 1'b1; bx = '0; by = 10'd480; bl = 1'b0; br = 1'b0; bj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", $signed(sx), 270);
    chk("reset_y", $signed(sy), 280);
    chk("reset_state", int'(st), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_air", int'(air), 0);
    rst = 1'b0;
    line(480, 6);
    chk("no_tick_on_release", tick_cnt, 0);

    // idle frames
    repeat (2) frame(0, 0, 0, 280, 0);
    drain();
    chk("ticks_per_frame", tick_cnt, 2);

    // left+right cancel
    repeat (5) frame(1, 1, 0, 280, 0);

    // single jump pulse; right held on the first rise frames
    frame(0, 0, 1, 280, 1);
    for (int i = 0; i < 12; i++) frame(0, i < 3, 0, rise_y[i], (i == 11) ? 2 : 1);
    for (int i = 0; i < 13; i++) frame(0, 0, 0, fall_y[i], (i == 12) ? 3 : 2);
    frame(0, 0, 0, 280, 0);

    // jump held: LAND ignores it, rejump next tick
    frame(0, 0, 1, 280, 1);
    for (int i = 0; i < 12; i++) frame(0, 0, 1, rise_y[i], (i == 11) ? 2 : 1);
    for (int i = 0; i < 13; i++) frame(0, 0, 1, fall_y[i], (i == 12) ? 3 : 2);
    frame(0, 0, 1, 280, 0);
    frame(0, 0, 1, 280, 1);
    for (int i = 0; i < 12; i++) frame(0, 0, 0, rise_y[i], (i == 11) ? 2 : 1);
    drain();
    chk("peak_y", $signed(sy), 202);

    // reset at peak, mid-line
    line(100, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_x", $signed(sx), 270);
    chk("midreset_y", $signed(sy), 280);
    chk("midreset_state", int'(st), 0);
    chk("midreset_air", int'(air), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    xm = 270;
    line(100, 5);
    chk("no_tick_after_midreset", tick_cnt, frames);
    frame(0, 0, 0, 280, 0);

    // right saturation / wrap, then left
    repeat (200) frame(0, 1, 0, 280, 0);
    drain();
`ifdef SPRITE_WRAP_EN
    chk("x_after_right", $signed(sx), 430);
`else
    chk("x_after_right", $signed(sx), 540);
`endif
    repeat (140) frame(1, 0, 0, 280, 0);
    drain();
`ifdef SPRITE_WRAP_EN
    chk("x_after_left", $signed(sx), 510);
`else
    chk("x_after_left", $signed(sx), 0);
`endif
    chk("tick_total", tick_cnt, frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
